// File: rtl/async_oneway_transmitter.sv
// rtl/async_oneway_transmitter.sv - chunked one-way message transmitter with pulse/commit strobes
// Optional one-deep pending request buffer enabled by ASYNC_TX_PENDING_REQ_EN.
module async_oneway_transmitter #(
    parameter int HOLD_CYCLES  = 16,
    parameter int MESSAGE_SIZE = 100
) (
    input  logic                    clk_send,
    input  logic                    rst,
    input  logic                    send_req,
    input  logic [MESSAGE_SIZE-1:0] message,
    output logic                    busy,
    output logic                    done,
    output logic [5:0]              dout,
    output logic                    packet_pulse,
    output logic                    transmit_ctrl
);

    localparam int         NCHUNK      = (MESSAGE_SIZE + 5) / 6;
    localparam int         SHIFT_W     = 6 * NCHUNK;
    localparam int         CNT_W       = $clog2(NCHUNK + 1);
    localparam logic [7:0] HOLD_RELOAD = 8'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        SETTLE,
        COMMIT,
        RELEASE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_hold;
    logic [SHIFT_W-1:0] r_shift;
    logic [CNT_W-1:0]   r_chunk;
    logic               r_busy;
    logic               r_done;
    logic [5:0]         r_dout;
    logic               r_pp;
    logic               r_tc;

    logic               w_hold_zero;
    logic               w_last_chunk;
    logic               w_enter;
    logic               w_pend_any;
    logic [SHIFT_W-1:0] w_shifted;

`ifdef ASYNC_TX_PENDING_REQ_EN
    logic                    r_pend_vld;
    logic [MESSAGE_SIZE-1:0] r_pend_msg;
    logic [MESSAGE_SIZE-1:0] w_pend_msg;

    // A request arriving in the final RELEASE cycle is newer than the stored one.
    assign w_pend_any = r_pend_vld | send_req;
    assign w_pend_msg = send_req ? message : r_pend_msg;
`else
    assign w_pend_any = 1'b0;
`endif

    assign w_hold_zero  = (r_hold == 8'd0);
    assign w_last_chunk = (r_chunk == CNT_W'(NCHUNK - 1));
    assign w_shifted    = r_shift >> 6;
    assign w_enter      = (w_state_nxt != r_state);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (send_req)    w_state_nxt = SETUP;
            SETUP:   if (w_hold_zero) w_state_nxt = STROBE;
            STROBE:  if (w_hold_zero) w_state_nxt = w_last_chunk ? SETTLE : SETUP;
            SETTLE:  if (w_hold_zero) w_state_nxt = COMMIT;
            COMMIT:  if (w_hold_zero) w_state_nxt = RELEASE;
            RELEASE: if (w_hold_zero) w_state_nxt = w_pend_any ? SETUP : IDLE;
            default:                  w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_send) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_send) begin
        if (rst) begin
            r_hold  <= 8'd0;
            r_shift <= '0;
            r_chunk <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dout  <= 6'd0;
            r_pp    <= 1'b0;
            r_tc    <= 1'b0;
`ifdef ASYNC_TX_PENDING_REQ_EN
            r_pend_vld <= 1'b0;
            r_pend_msg <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_enter)          r_hold <= HOLD_RELOAD;
            else if (!w_hold_zero) r_hold <= r_hold - 8'd1;
`ifdef ASYNC_TX_PENDING_REQ_EN
            if (r_busy && send_req) begin
                r_pend_vld <= 1'b1;
                r_pend_msg <= message;
            end
`endif
            case (r_state)
                IDLE: if (send_req) begin
                    r_shift <= SHIFT_W'(message);
                    r_chunk <= '0;
                    r_dout  <= message[5:0];
                    r_busy  <= 1'b1;
                end
                SETUP:  if (w_hold_zero) r_pp <= 1'b1;
                STROBE: if (w_hold_zero) begin
                    r_pp    <= 1'b0;
                    r_shift <= w_shifted;
                    r_chunk <= r_chunk + 1'b1;
                    if (!w_last_chunk) r_dout <= w_shifted[5:0];
                end
                SETTLE: if (w_hold_zero) r_tc <= 1'b1;
                COMMIT: if (w_hold_zero) r_tc <= 1'b0;
                RELEASE: if (w_hold_zero) begin
                    r_done <= 1'b1;
`ifdef ASYNC_TX_PENDING_REQ_EN
                    if (w_pend_any) begin
                        r_shift    <= SHIFT_W'(w_pend_msg);
                        r_chunk    <= '0;
                        r_dout     <= w_pend_msg[5:0];
                        r_pend_vld <= 1'b0;
                    end else begin
                        r_busy <= 1'b0;
                    end
`else
                    r_busy <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign dout          = r_dout;
    assign packet_pulse  = r_pp;
    assign transmit_ctrl = r_tc;

endmodule

// File: tb/tb_async_oneway_transmitter.sv
// tb/tb_async_oneway_transmitter.sv - directed and randomized bench with a receiver model
module tb_async_oneway_transmitter;

    localparam int H        = 4;
    localparam int MSZ      = 100;
    localparam int NCHUNK   = (MSZ + 5) / 6;
    localparam int XFER_CYC = (2 * NCHUNK + 3) * H;
    localparam int LIMIT    = 4 * XFER_CYC;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           send_req = 1'b0;
    logic [MSZ-1:0] message = '0;
    logic           busy, done, packet_pulse, transmit_ctrl;
    logic [5:0]     dout;

    int n_checks = 0;
    int n_fail   = 0;

    int busy_cnt = 0, done_cnt = 0, pp_rise = 0, tc_rise = 0;
    int overlap_cnt = 0, dout_glitch = 0;
    logic             pp_prev = 1'b0, tc_prev = 1'b0;
    logic [5:0]       dout_prev = '0;
    logic [5:0]       rx_q[$];
    logic [5:0]       log_q[$];
    logic [6*NCHUNK-1:0] rx_buf = '0;

    async_oneway_transmitter #(.HOLD_CYCLES(H), .MESSAGE_SIZE(MSZ)) dut (
        .clk_send     (clk),
        .rst          (rst),
        .send_req     (send_req),
        .message      (message),
        .busy         (busy),
        .done         (done),
        .dout         (dout),
        .packet_pulse (packet_pulse),
        .transmit_ctrl(transmit_ctrl)
    );

    always #5 clk = ~clk;

    // Receiver: shift register of the last NCHUNK chunks, latched on the commit strobe.
    always @(negedge clk) begin
        logic [6*NCHUNK-1:0] tmp;
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        if (packet_pulse && transmit_ctrl) overlap_cnt++;
        if (pp_prev && packet_pulse && dout !== dout_prev) dout_glitch++;
        if (packet_pulse && !pp_prev) begin
            pp_rise++;
            log_q.push_back(dout);
            rx_q.push_back(dout);
            if (rx_q.size() > NCHUNK) void'(rx_q.pop_front());
        end
        if (transmit_ctrl && !tc_prev) begin
            tc_rise++;
            tmp = '0;
            for (int k = 0; k < rx_q.size(); k++) tmp[6*k +: 6] = rx_q[k];
            rx_buf = tmp;
        end
        pp_prev   = packet_pulse;
        tc_prev   = transmit_ctrl;
        dout_prev = dout;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [MSZ-1:0] rand_msg();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[MSZ-1:0];
    endfunction

    function automatic logic [5:0] exp_chunk(input logic [MSZ-1:0] m, input int k);
        logic [6*NCHUNK-1:0] ext;
        ext = {{(6*NCHUNK-MSZ){1'b0}}, m};
        return 6'((ext >> (6 * k)) & 63);
    endfunction

    task automatic wait_done(input int target, input string tag);
        int t = 0;
        while (done_cnt < target && t < LIMIT) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        check(tag, done_cnt >= target, 1'b1);
    endtask

    task automatic send(input logic [MSZ-1:0] msg);
        int d0;
        d0 = done_cnt;
        log_q.delete();
        @(negedge clk);
        message  = msg;
        send_req = 1'b1;
        @(negedge clk);
        send_req = 1'b0;
        message  = rand_msg();
        wait_done(d0 + 1, "done_seen");
    endtask

    initial begin
        logic [MSZ-1:0] m, m2;
        logic [6*NCHUNK-1:0] buf_before;
        int b0, d0, p0, t0, w;

        repeat (3) @(negedge clk);
        check("rst_dout", dout, 6'd0);
        check("rst_pp", packet_pulse, 1'b0);
        check("rst_tc", transmit_ctrl, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);

        send_req = 1'b1;
        message  = rand_msg();
        @(negedge clk);
        send_req = 1'b0;
        @(negedge clk);
        check("req_during_rst", busy, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        b0 = busy_cnt; p0 = pp_rise; t0 = tc_rise; d0 = done_cnt;
        m = '0; m[0] = 1'b1;
        send(m);
        check("one_pp_rises", pp_rise - p0, NCHUNK);
        check("one_tc_rises", tc_rise - t0, 1);
        check("one_busy_cycles", busy_cnt - b0, 148);
        check("one_done_pulses", done_cnt - d0, 1);
        for (int k = 0; k < NCHUNK; k++)
            check($sformatf("one_chunk%0d", k), log_q[k], (k == 0) ? 6'h01 : 6'h00);
        check("one_read_buffer", rx_buf, {{(6*NCHUNK-MSZ){1'b0}}, m});

        m = '1;
        send(m);
        check("ones_chunk0", log_q[0], 6'h3F);
        check("ones_chunk15", log_q[15], 6'h3F);
        check("ones_chunk16", log_q[16], 6'h0F);
        check("ones_read_buffer", rx_buf, {{(6*NCHUNK-MSZ){1'b0}}, m});

        buf_before = rx_buf;
        t0 = tc_rise; p0 = pp_rise;
        @(negedge clk);
        message  = rand_msg();
        send_req = 1'b1;
        @(negedge clk);
        send_req = 1'b0;
        w = 0;
        while (pp_rise - p0 < 9 && w < LIMIT) begin @(negedge clk); w++; end
        check("abort_reached_chunk8", pp_rise - p0, 9);
        check("abort_in_strobe", packet_pulse, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_dout", dout, 6'd0);
        check("abort_pp", packet_pulse, 1'b0);
        check("abort_tc", transmit_ctrl, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        repeat (2 * XFER_CYC) @(negedge clk);
        check("abort_no_commit", tc_rise - t0, 0);
        check("abort_buffer_kept", rx_buf, buf_before);

        b0 = busy_cnt; d0 = done_cnt; t0 = tc_rise;
        m  = rand_msg();
        m2 = rand_msg();
        @(negedge clk);
        message  = m;
        send_req = 1'b1;
        @(negedge clk);
        send_req = 1'b0;
        repeat (XFER_CYC / 2) @(negedge clk);
        message  = m2;
        send_req = 1'b1;
        @(negedge clk);
        send_req = 1'b0;
        message  = rand_msg();
`ifdef ASYNC_TX_PENDING_REQ_EN
        wait_done(d0 + 2, "pend_done_seen");
        repeat (XFER_CYC) @(negedge clk);
        check("pend_done_pulses", done_cnt - d0, 2);
        check("pend_busy_cycles", busy_cnt - b0, 2 * XFER_CYC);
        check("pend_commits", tc_rise - t0, 2);
        check("pend_read_buffer", rx_buf, {{(6*NCHUNK-MSZ){1'b0}}, m2});
`else
        wait_done(d0 + 1, "nopend_done_seen");
        repeat (XFER_CYC) @(negedge clk);
        check("nopend_done_pulses", done_cnt - d0, 1);
        check("nopend_busy_cycles", busy_cnt - b0, XFER_CYC);
        check("nopend_commits", tc_rise - t0, 1);
        check("nopend_read_buffer", rx_buf, {{(6*NCHUNK-MSZ){1'b0}}, m});
`endif

        for (int i = 0; i < 200; i++) begin
            m = rand_msg();
            send(m);
            check($sformatf("rand%0d_chunk%0d", i, i % NCHUNK), log_q[i % NCHUNK], exp_chunk(m, i % NCHUNK));
            check($sformatf("rand%0d_read_buffer", i), rx_buf, {{(6*NCHUNK-MSZ){1'b0}}, m});
        end

        check("pp_tc_overlap", overlap_cnt, 0);
        check("dout_change_in_strobe", dout_glitch, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
